wb_select_stage: RTL and testbench

Registered writeback-select stage between the ALU and the register file, generalising the combinational ALU output mux. Per accepted instruction it selects ALU result or branch immediate by opcode, gates the register-file write with the condition-check result, and registers data, destination and enable for one-cycle latency. Branch-with-link is sequenced over two output cycles (branch, then link-register write) with input back-pressure. It also supports pipeline flush and keeps a retired-instruction counter.

---
 rtl/wb_select_if.sv | 50 +++++
 rtl/wb_select_stage.sv | 121 ++++++++++++
 tb/tb_wb_select_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_select_if.sv
// wb_select_if: bundles the instruction-side handshake and the writeback-side
// outputs of wb_select_stage.
//   slave  : the stage itself (consumes the instruction, drives writeback)
//   master : the producer/observer (drives the instruction, sees writeback)
// Signals:
//   in_valid/in_ready             instruction handshake
//   opcode, alu_result, branch_immediate, link_value, dest_reg,
//   wb_test, cond_execute         instruction payload
//   flush                         kill registered and pending work
//   wb_valid/wb_enable/wb_addr/wb_data   register-file write port
//   branch_taken/branch_target    PC redirect
//   retire_count                  retired-instruction counter
interface wb_select_if #(
  parameter int DATA_W  = 32,
  parameter int OPC_W   = 5,
  parameter int RADDR_W = 4,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [OPC_W-1:0]   opcode;
  logic [DATA_W-1:0]  alu_result;
  logic [DATA_W-1:0]  branch_immediate;
  logic [DATA_W-1:0]  link_value;
  logic [RADDR_W-1:0] dest_reg;
  logic               wb_test;
  logic               cond_execute;
  logic               flush;
  logic               wb_valid;
  logic               wb_enable;
  logic [RADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               branch_taken;
  logic [DATA_W-1:0]  branch_target;
  logic [CNT_W-1:0]   retire_count;

  modport slave (
    input  in_valid, opcode, alu_result, branch_immediate, link_value,
           dest_reg, wb_test, cond_execute, flush,
    output in_ready, wb_valid, wb_enable, wb_addr, wb_data,
           branch_taken, branch_target, retire_count
  );

  modport master (
    output in_valid, opcode, alu_result, branch_immediate, link_value,
           dest_reg, wb_test, cond_execute, flush,
    input  in_ready, wb_valid, wb_enable, wb_addr, wb_data,
           branch_taken, branch_target, retire_count
  );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage: registered writeback select between ALU and register file.
// Selects ALU result or branch immediate, gates the write with the condition
// check, registers everything for one-cycle latency, sequences branch-with-link
// as a branch cycle followed by a link-register write, and counts retirements.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    wb_select_if.slave (instruction in, writeback/redirect out)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an instruction (in_ready=1)
// LINK  | BL branch issued last cycle; emit link-register write now
module wb_select_stage #(
  parameter int               DATA_W     = 32,
  parameter int               OPC_W      = 5,
  parameter int               RADDR_W    = 4,
  parameter logic [OPC_W-1:0] BRANCH_OPC = 5'b10001,
  parameter logic [OPC_W-1:0] BL_OPC     = 5'b10010,
  parameter int               LR_ADDR    = 14,
  parameter int               CNT_W      = 16
) (
  input logic        clk,
  input logic        reset,
  wb_select_if.slave bus
);

  typedef enum logic {IDLE, LINK} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic               en_q, en_d;
  logic [RADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               taken_q, taken_d;
  logic [DATA_W-1:0]  target_q, target_d;
  logic [DATA_W-1:0]  link_q, link_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic is_br, is_bl;
  assign is_br = (bus.opcode == BRANCH_OPC);
  assign is_bl = (bus.opcode == BL_OPC);

  always_comb begin
    state_d  = state_q;
    valid_d  = 1'b0;
    en_d     = 1'b0;
    taken_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    target_d = target_q;
    link_d   = link_q;
    cnt_d    = cnt_q;
    // flush overrides everything: outputs go quiet and a pending LR write is lost
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            valid_d  = 1'b1;
            addr_d   = bus.dest_reg;
            data_d   = is_br ? bus.branch_immediate : bus.alu_result;
            en_d     = bus.wb_test && bus.cond_execute;
            taken_d  = bus.cond_execute && (is_br || is_bl);
            target_d = bus.branch_immediate;
            cnt_d    = cnt_q + CNT_W'(1);
            // a taken BL writes only via the following LINK cycle
            if (is_bl && bus.cond_execute) begin
              en_d    = 1'b0;
              link_d  = bus.link_value;
              state_d = LINK;
            end
          end
        end
        LINK: begin
          valid_d = 1'b1;
          en_d    = 1'b1;
          addr_d  = RADDR_W'(LR_ADDR);
          data_d  = link_q;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      link_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      en_q     <= en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      link_q   <= link_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready      = (state_q == IDLE);
  assign bus.wb_valid      = valid_q;
  assign bus.wb_enable     = en_q;
  assign bus.wb_addr       = addr_q;
  assign bus.wb_data       = data_q;
  assign bus.branch_taken  = taken_q;
  assign bus.branch_target = target_q;
  assign bus.retire_count  = cnt_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage (retire counter built 2 bits wide so
// that wrap-around is exercised constantly).
module tb_wb_select_stage;
  localparam int DW = 32;
  localparam int OW = 5;
  localparam int RW = 4;
  localparam int CW = 2;
  localparam logic [4:0] OP_BR = 5'b10001;
  localparam logic [4:0] OP_BL = 5'b10010;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_select_if #(.DATA_W(DW), .OPC_W(OW), .RADDR_W(RW), .CNT_W(CW)) bus ();

  wb_select_stage #(.DATA_W(DW), .OPC_W(OW), .RADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: output slot contents plus a queue of pending link writes
  bit         m_valid, m_en, m_taken;
  logic [3:0] m_addr;
  logic [31:0] m_data, m_target;
  int         m_cnt;
  logic [31:0] pend[$];

  typedef struct {
    logic [4:0]  opc;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [3:0]  dest;
    bit          wbt;
    bit          cond;
    bit          e_en;
    logic [31:0] e_data;
    bit          e_taken;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_valid = 0; m_en = 0; m_taken = 0;
    m_addr = '0; m_data = '0; m_target = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (bus.flush) begin
      pend.delete();
      m_valid = 0; m_en = 0; m_taken = 0;
    end else if (pend.size() > 0) begin
      m_valid = 1; m_en = 1; m_taken = 0;
      m_addr = 4'd14;
      m_data = pend.pop_front();
    end else if (bus.in_valid) begin
      bit br, bl;
      br = (bus.opcode == OP_BR);
      bl = (bus.opcode == OP_BL);
      m_valid  = 1;
      m_addr   = bus.dest_reg;
      m_data   = br ? bus.branch_immediate : bus.alu_result;
      m_taken  = bus.cond_execute && (br || bl);
      m_target = bus.branch_immediate;
      m_en     = bus.wb_test && bus.cond_execute && !(bl && bus.cond_execute);
      m_cnt    = (m_cnt + 1) % (1 << CW);
      if (bl && bus.cond_execute) pend.push_back(bus.link_value);
    end else begin
      m_valid = 0; m_en = 0; m_taken = 0;
    end
  endtask

  task automatic check_all();
    chk("in_ready", bus.in_ready, (pend.size() == 0));
    chk("wb_valid", bus.wb_valid, m_valid);
    chk("wb_enable", bus.wb_enable, m_en);
    chk("wb_addr", bus.wb_addr, m_addr);
    chk("wb_data", bus.wb_data, m_data);
    chk("branch_taken", bus.branch_taken, m_taken);
    chk("branch_target", bus.branch_target, m_target);
    chk("retire_count", bus.retire_count, m_cnt);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [4:0] opc, input logic [31:0] alu, input logic [31:0] imm,
                       input logic [31:0] lnk, input logic [3:0] dest, input bit wbt,
                       input bit cond, input bit fl, input bit vld);
    bus.opcode = opc; bus.alu_result = alu; bus.branch_immediate = imm;
    bus.link_value = lnk; bus.dest_reg = dest; bus.wb_test = wbt;
    bus.cond_execute = cond; bus.flush = fl; bus.in_valid = vld;
  endtask

  task automatic idle();
    bus.in_valid = 0;
    bus.flush = 0;
  endtask

  // called #1 after a rising edge: reset asserts mid-cycle, releases after next edge
  task automatic do_reset();
    #3;
    reset = 1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 0;
    check_all();
  endtask

  vec_t vecs[7];
  int   wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    vecs[0] = '{5'd0,  32'hA5A5, 32'h1,    4'd1,  1, 1, 1, 32'hA5A5, 0};
    vecs[1] = '{5'd3,  32'h0F,   32'h2,    4'd2,  1, 0, 0, 32'h0F,   0};
    vecs[2] = '{OP_BR, 32'h9,    32'h1000, 4'd3,  1, 1, 1, 32'h1000, 1};
    vecs[3] = '{OP_BR, 32'h9,    32'h2000, 4'd4,  1, 0, 0, 32'h2000, 0};
    vecs[4] = '{OP_BL, 32'h33,   32'h3000, 4'd5,  1, 0, 0, 32'h33,   0};
    vecs[5] = '{5'h1F, 32'h44,   32'h4000, 4'd6,  0, 1, 0, 32'h44,   0};
    vecs[6] = '{5'h10, 32'h55,   32'h5000, 4'd15, 1, 1, 1, 32'h55,   0};

    reset = 1;
    drive(5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_all();
    @(posedge clk);
    #1;
    reset = 0;
    check_all();

    // ALU op
    drive(5'd0, 32'h1234, 32'h0, 0, 4'd3, 1, 1, 0, 1);
    step();
    chk("alu_en", bus.wb_enable, 1);
    chk("alu_addr", bus.wb_addr, 3);
    chk("alu_data", bus.wb_data, 32'h1234);
    chk("alu_taken", bus.branch_taken, 0);
    chk("alu_cnt", bus.retire_count, 1);

    // plain branch, taken then not taken
    drive(OP_BR, 32'hDEAD, 32'h400, 0, 4'd5, 0, 1, 0, 1);
    step();
    chk("br_data", bus.wb_data, 32'h400);
    chk("br_taken", bus.branch_taken, 1);
    chk("br_target", bus.branch_target, 32'h400);
    chk("br_en", bus.wb_enable, 0);
    drive(OP_BR, 32'hDEAD, 32'h400, 0, 4'd5, 0, 0, 0, 1);
    step();
    chk("br_nc_taken", bus.branch_taken, 0);

    // BL with a follow-on op held during the LINK cycle
    drive(OP_BL, 32'h55, 32'h800, 32'h104, 4'd2, 1, 1, 0, 1);
    step();
    chk("bl_taken", bus.branch_taken, 1);
    chk("bl_target", bus.branch_target, 32'h800);
    chk("bl_ready", bus.in_ready, 0);
    chk("bl_en", bus.wb_enable, 0);
    chk("bl_cnt", bus.retire_count, 0);
    drive(5'd0, 32'h77, 32'h0, 0, 4'd6, 1, 1, 0, 1);
    step();
    chk("lr_en", bus.wb_enable, 1);
    chk("lr_addr", bus.wb_addr, 14);
    chk("lr_data", bus.wb_data, 32'h104);
    chk("lr_taken", bus.branch_taken, 0);
    chk("lr_cnt", bus.retire_count, 0);
    step();
    chk("post_lr_addr", bus.wb_addr, 6);
    chk("post_lr_data", bus.wb_data, 32'h77);
    chk("post_lr_cnt", bus.retire_count, 1);

    // flush during the LINK cycle
    drive(OP_BL, 32'h1, 32'h900, 32'h208, 4'd7, 0, 1, 0, 1);
    step();
    drive(5'd0, 32'h99, 32'h0, 0, 4'd8, 1, 1, 1, 1);
    step();
    chk("fl_valid", bus.wb_valid, 0);
    chk("fl_en", bus.wb_enable, 0);
    chk("fl_ready", bus.in_ready, 1);
    idle();
    step();
    chk("fl_after_en", bus.wb_enable, 0);

    // flush together with a valid input in IDLE: input lost
    drive(5'd0, 32'hAB, 32'h0, 0, 4'd9, 1, 1, 1, 1);
    step();
    chk("fl_in_valid", bus.wb_valid, 0);
    chk("fl_in_cnt", bus.retire_count, 2);
    idle();
    step();

    // reset in the middle of a LINK cycle drops the LR write
    drive(OP_BL, 32'h2, 32'hA00, 32'h30C, 4'd1, 0, 1, 0, 1);
    step();
    idle();
    do_reset();
    chk("rst_valid", bus.wb_valid, 0);
    chk("rst_cnt", bus.retire_count, 0);
    step();
    chk("rst_no_lr", bus.wb_enable, 0);

    // counter wrap: five retiring instructions back to back
    for (int i = 0; i < 5; i++) begin
      drive(5'd0, 32'(i), 32'h0, 0, 4'(i), 1, 1, 0, 1);
      step();
      chk("wrap_cnt", bus.retire_count, wrap_exp[i]);
    end
    idle();
    step();

    // table-driven single-cycle vectors, back to back
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].opc, vecs[i].alu, vecs[i].imm, 32'hFFFF, vecs[i].dest,
            vecs[i].wbt, vecs[i].cond, 0, 1);
      step();
      chk("vec_en", bus.wb_enable, vecs[i].e_en);
      chk("vec_data", bus.wb_data, vecs[i].e_data);
      chk("vec_taken", bus.branch_taken, vecs[i].e_taken);
      chk("vec_addr", bus.wb_addr, vecs[i].dest);
      chk("vec_target", bus.branch_target, vecs[i].imm);
    end
    idle();
    step();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] opc;
      int r;
      r = $urandom_range(0, 3);
      opc = (r == 0) ? OP_BR : (r == 1) ? OP_BL : 5'($urandom);
      drive(opc, $urandom, $urandom, $urandom, 4'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      step();
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
